// File: rtl/dds_phase_accumulator.sv
// ---------------------------------------------------------------------------
// dds_phase_accumulator
// Purpose: NCO phase generator for a sine ROM. It integrates a frequency
// tuning word on every enabled cycle, adds a phase offset, and outputs the top
// OUT_WIDTH bits as the ROM address. An FTW that is loaded while running waits
// in a shadow register until the next accumulator wrap, so the output period
// never glitches.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   enable            accumulate this cycle (0 = hold)
//   phase_clr         synchronous clear of accumulator and wrap counter
//   ftw_in, ftw_load  tuning word and its one-cycle capture strobe
//   offset_in         phase offset, sampled every cycle
//   phase_out         ROM address (top bits of acc + offset), registered
//   phase_valid       phase_out comes from an enabled accumulation
//   wrap              one-cycle pulse on accumulator carry-out
//   ftw_pending       a shadowed FTW is waiting for the next wrap
//   wrap_count        wraps since reset/clear, modulo 2^16
// ---------------------------------------------------------------------------
module dds_phase_accumulator #(
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 phase_clr,
    input  logic [ACC_WIDTH-1:0] ftw_in,
    input  logic                 ftw_load,
    input  logic [ACC_WIDTH-1:0] offset_in,
    output logic [OUT_WIDTH-1:0] phase_out,
    output logic                 phase_valid,
    output logic                 wrap,
    output logic                 ftw_pending,
    output logic [15:0]          wrap_count
);

    localparam int unsigned CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q,        acc_d;
    logic [ACC_WIDTH-1:0]   ftw_active_q, ftw_active_d;
    logic [ACC_WIDTH-1:0]   ftw_shadow_q, ftw_shadow_d;
    logic                   pending_q,    pending_d;
    logic                   wrap_q,       wrap_d;
    logic [CNT_WIDTH-1:0]   wrap_count_q, wrap_count_d;
    logic [OUT_WIDTH-1:0]   phase_q,      phase_d;
    logic                   enable_q;
    logic                   valid_q;

    logic [ACC_WIDTH:0]     sum_c;
    logic                   carry_c;
    logic [ACC_WIDTH-1:0]   offset_sum_c;

    // Extra top bit of the sum captures the accumulator carry-out.
    assign sum_c        = {1'b0, acc_q} + {1'b0, ftw_active_q};
    assign carry_c      = enable && !phase_clr && sum_c[ACC_WIDTH];
    assign offset_sum_c = acc_q + offset_in;

    // Next-state logic for the accumulator, wrap tracking and FTW registers.
    always_comb begin
        acc_d        = acc_q;
        wrap_d       = 1'b0;
        wrap_count_d = wrap_count_q;
        ftw_active_d = ftw_active_q;
        ftw_shadow_d = ftw_shadow_q;
        pending_d    = pending_q;
        phase_d      = offset_sum_c[ACC_WIDTH-1 -: OUT_WIDTH];

        if (phase_clr) begin
            acc_d        = '0;
            wrap_count_d = '0;
        end else if (enable) begin
            acc_d  = sum_c[ACC_WIDTH-1:0];
            wrap_d = sum_c[ACC_WIDTH];
            if (sum_c[ACC_WIDTH]) begin
                wrap_count_d = wrap_count_q + CNT_WIDTH'(1);
            end
        end

        if (ftw_load && (state_q != RUN)) begin
            // Not running: no waveform to protect, so apply immediately.
            ftw_active_d = ftw_in;
            pending_d    = 1'b0;
        end else begin
            // Commit uses the pre-edge shadow; a same-edge load refills it.
            if (carry_c && pending_q) begin
                ftw_active_d = ftw_shadow_q;
                pending_d    = 1'b0;
            end
            if (ftw_load) begin
                ftw_shadow_d = ftw_in;
                pending_d    = 1'b1;
            end
        end
    end

    // Control state: IDLE until first enable, then RUN/HOLD follow enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable)  state_q <= RUN;
                RUN:     if (!enable) state_q <= HOLD;
                HOLD:    if (enable)  state_q <= RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            ftw_active_q <= '0;
            ftw_shadow_q <= '0;
            pending_q    <= 1'b0;
            wrap_q       <= 1'b0;
            wrap_count_q <= '0;
            phase_q      <= '0;
            enable_q     <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ftw_active_q <= ftw_active_d;
            ftw_shadow_q <= ftw_shadow_d;
            pending_q    <= pending_d;
            wrap_q       <= wrap_d;
            wrap_count_q <= wrap_count_d;
            phase_q      <= phase_d;
            enable_q     <= enable;
            // Delayed one more edge so it lines up with phase_out.
            valid_q      <= enable_q;
        end
    end

    assign phase_out   = phase_q;
    assign phase_valid = valid_q;
    assign wrap        = wrap_q;
    assign ftw_pending = pending_q;
    assign wrap_count  = wrap_count_q;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// ---------------------------------------------------------------------------
// tb_dds_phase_accumulator
// Purpose: self-checking bench for dds_phase_accumulator. A cycle-level
// arithmetic reference model predicts every registered output. The bench runs
// directed scenarios first and then a randomized soak.
// ---------------------------------------------------------------------------
module tb_dds_phase_accumulator;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned OUT_W = 8;
    localparam longint unsigned MOD = 64'd1 << ACC_W;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             phase_clr;
    logic [ACC_W-1:0] ftw_in;
    logic             ftw_load;
    logic [ACC_W-1:0] offset_in;
    logic [OUT_W-1:0] phase_out;
    logic             phase_valid;
    logic             wrap;
    logic             ftw_pending;
    logic [15:0]      wrap_count;

    dds_phase_accumulator #(.ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .phase_clr   (phase_clr),
        .ftw_in      (ftw_in),
        .ftw_load    (ftw_load),
        .offset_in   (offset_in),
        .phase_out   (phase_out),
        .phase_valid (phase_valid),
        .wrap        (wrap),
        .ftw_pending (ftw_pending),
        .wrap_count  (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (plain integers).
    longint unsigned m_acc, m_active, m_shadow, m_count, m_phase;
    bit m_pending, m_wrap, m_valid, m_en_prev, m_en_prev2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit will_carry();
        return !reset && !phase_clr && enable && ((m_acc + m_active) >= MOD);
    endfunction

    // The block is "running" iff the previous edge was enabled.
    task automatic model_edge();
        longint unsigned s;
        bit carry;
        bit running;
        if (reset) begin
            m_acc = 0; m_active = 0; m_shadow = 0; m_count = 0; m_phase = 0;
            m_pending = 0; m_wrap = 0; m_valid = 0; m_en_prev = 0; m_en_prev2 = 0;
            return;
        end
        running = m_en_prev;
        m_phase = ((m_acc + longint'(offset_in)) % MOD) >> (ACC_W - OUT_W);
        m_valid = m_en_prev;
        carry   = 0;
        if (phase_clr) begin
            m_acc = 0; m_wrap = 0; m_count = 0;
        end else if (enable) begin
            s      = m_acc + m_active;
            carry  = (s >= MOD);
            m_acc  = s % MOD;
            m_wrap = carry;
            if (carry) m_count = (m_count + 1) % 65536;
        end else begin
            m_wrap = 0;
        end
        if (ftw_load && !running) begin
            m_active  = longint'(ftw_in);
            m_pending = 0;
        end else begin
            if (carry && m_pending) begin
                m_active  = m_shadow;
                m_pending = 0;
            end
            if (ftw_load) begin
                m_shadow  = longint'(ftw_in);
                m_pending = 1;
            end
        end
        m_en_prev = enable;
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("phase_out",   64'(phase_out),   64'(m_phase));
        chk("phase_valid", 64'(phase_valid), 64'(m_valid));
        chk("wrap",        64'(wrap),        64'(m_wrap));
        chk("ftw_pending", 64'(ftw_pending), 64'(m_pending));
        chk("wrap_count",  64'(wrap_count),  m_count);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int guard;
        reset = 1; enable = 0; phase_clr = 0; ftw_in = '0; ftw_load = 0; offset_in = '0;

        // Reset state.
        run(2);
        chk("rst_phase", 64'(phase_out), 64'd0);
        chk("rst_count", 64'(wrap_count), 64'd0);
        chk("rst_pend",  64'(ftw_pending), 64'd0);
        reset = 0;

        // Direct load in IDLE, then a slow ramp through one full wrap.
        ftw_in = 32'h0100_0000; ftw_load = 1; cyc(); ftw_load = 0;
        enable = 1;
        run(300);
        chk("ramp_count", 64'(wrap_count), 64'd1);

        // Half-rate FTW loaded in HOLD, cleared, then 100 enabled cycles.
        enable = 0; cyc();
        ftw_in = 32'h8000_0000; ftw_load = 1; phase_clr = 1; cyc();
        ftw_load = 0; phase_clr = 0;
        enable = 1;
        run(100);
        chk("half_count50", 64'(wrap_count), 64'd50);
        run(5);

        // Deferred load: step stays old until the wrap, then commits.
        enable = 0; cyc();
        ftw_in = 32'h0100_0000; ftw_load = 1; phase_clr = 1; cyc();
        ftw_load = 0; phase_clr = 0;
        enable = 1; run(16);
        ftw_in = 32'h0200_0000; ftw_load = 1; cyc(); ftw_load = 0;
        chk("defer_pend", 64'(ftw_pending), 64'd1);
        run(260);
        chk("defer_commit", 64'(ftw_pending), 64'd0);

        // Two loads before the wrap plus one on the carry edge itself.
        enable = 0; cyc();
        ftw_in = 32'h0100_0000; ftw_load = 1; phase_clr = 1; cyc();
        ftw_load = 0; phase_clr = 0;
        enable = 1; run(10);
        ftw_in = 32'h0200_0000; ftw_load = 1; cyc(); ftw_load = 0;
        run(5);
        ftw_in = 32'h0400_0000; ftw_load = 1; cyc(); ftw_load = 0;
        guard = 0;
        while (!will_carry() && guard < 1000) begin cyc(); guard++; end
        chk("carry_found", 64'(guard < 1000), 64'd1);
        ftw_in = 32'h0800_0000; ftw_load = 1; cyc(); ftw_load = 0;
        chk("same_edge_pend", 64'(ftw_pending), 64'd1);
        chk("same_edge_active", m_active, 64'h0400_0000);
        run(80);

        // Offset with acc cleared in HOLD; then clear mid-run keeps pending FTW.
        enable = 0; cyc();
        phase_clr = 1; offset_in = 32'h4000_0000; cyc();
        phase_clr = 0; cyc();
        chk("offset_40", 64'(phase_out), 64'h40);
        offset_in = '0;
        enable = 1; run(7);
        ftw_in = 32'h0300_0000; ftw_load = 1; cyc(); ftw_load = 0;
        phase_clr = 1; cyc(); phase_clr = 0;
        chk("clr_count", 64'(wrap_count), 64'd0);
        chk("clr_pend",  64'(ftw_pending), 64'd1);
        run(3);

        // Reset mid-run with a pending FTW; afterwards nothing moves.
        ftw_in = 32'h0500_0000; ftw_load = 1; cyc(); ftw_load = 0;
        reset = 1; cyc(); reset = 0;
        chk("rst2_phase", 64'(phase_out), 64'd0);
        chk("rst2_pend",  64'(ftw_pending), 64'd0);
        enable = 1; run(20);
        chk("frozen_phase", 64'(phase_out), 64'd0);
        chk("frozen_count", 64'(wrap_count), 64'd0);

        // Randomized soak against the model.
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 799) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            phase_clr = ($urandom_range(0, 99) == 0);
            ftw_load  = ($urandom_range(0, 19) == 0);
            ftw_in    = ($urandom_range(0, 15) == 0) ? '0 : ($urandom >> $urandom_range(0, 6));
            offset_in = ($urandom_range(0, 3) == 0) ? $urandom : offset_in;
            cyc();
        end
        reset = 0; enable = 0; phase_clr = 0; ftw_load = 0;
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
